// File: rtl/dcache_ecc_scrubber.sv
// ---------------------------------------------------------------------------
// dcache_ecc_scrubber
//
// Background ECC scrub controller for the SECDED-protected data cache arrays.
// It walks every set index and, while the memory arbiter is otherwise idle,
// issues a lowest-priority read of all ways. It writes back corrected lines
// for ways that report a correctable error. It counts and flags
// uncorrectable errors.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   en_i                    scrubbing enable
//   interval_i              idle cycles between index scrubs
//   clr_cnt_i               synchronous clear of both error counters
//   req_o/we_o/way_o        arbiter request: read of all ways (we_o=0) or
//   index_o/wdata_o         one-hot way writeback (we_o=1) of wdata_o
//   gnt_i                   arbiter grant
//   err_corr_i              per-way correctable error, 1 cycle after read grant
//   err_uncorr_i            per-way uncorrectable error, same timing
//   corr_data_i             per-way corrected line, same timing
//   cache_we_i              a regular cache port writes cache_index_i this cycle
//   cache_index_i
//   corr_cnt_o              saturating count of corrected lines
//   uncorr_cnt_o            saturating count of uncorrectable read events
//   uncorr_irq_o            1-cycle pulse on an uncorrectable error
//   sweep_done_o            1-cycle pulse when the index wraps to 0
//   busy_o                  FSM is not idle
// ---------------------------------------------------------------------------
module dcache_ecc_scrubber #(
    parameter int NUM_WAYS = 8,
    parameter int NUM_SETS = 256,
    parameter int LINE_W   = 128,
    parameter int CNT_W    = 16,
    localparam int IDX_W   = $clog2(NUM_SETS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [15:0]                interval_i,
    input  logic                       clr_cnt_i,
    output logic                       req_o,
    output logic                       we_o,
    output logic [NUM_WAYS-1:0]        way_o,
    output logic [IDX_W-1:0]           index_o,
    output logic [LINE_W-1:0]          wdata_o,
    input  logic                       gnt_i,
    input  logic [NUM_WAYS-1:0]        err_corr_i,
    input  logic [NUM_WAYS-1:0]        err_uncorr_i,
    input  logic [NUM_WAYS*LINE_W-1:0] corr_data_i,
    input  logic                       cache_we_i,
    input  logic [IDX_W-1:0]           cache_index_i,
    output logic [CNT_W-1:0]           corr_cnt_o,
    output logic [CNT_W-1:0]           uncorr_cnt_o,
    output logic                       uncorr_irq_o,
    output logic                       sweep_done_o,
    output logic                       busy_o
);

    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int PC_W  = $clog2(NUM_WAYS + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD_REQ,
        RD_CHK,
        WR_REQ
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    index_q;
    logic [15:0]         wait_q;
    logic [NUM_WAYS-1:0] pending_q;
    logic [LINE_W-1:0]   line_q [NUM_WAYS];
    logic [CNT_W-1:0]    corr_cnt_q, uncorr_cnt_q;
    logic                irq_q, sweep_q;

    logic                load_wait, dec_wait, sample, advance, pop, drop;
    logic                collision;
    logic [NUM_WAYS-1:0] pend_new, lowest;
    logic [WAY_W-1:0]    lowest_idx;
    logic [PC_W-1:0]     pop_cnt;
    logic [SUM_W-1:0]    corr_sum;
    logic [CNT_W-1:0]    corr_sat, uncorr_inc;

    // A regular write to the index being scrubbed makes any read result stale.
    assign collision = cache_we_i && (cache_index_i == index_q);
    // Ways that are also uncorrectable must never be "repaired" by a writeback.
    assign pend_new  = err_corr_i & ~err_uncorr_i;
    assign lowest    = pending_q & (~pending_q + NUM_WAYS'(1));

    // Pick the way to write back and count the freshly found correctable ways;
    // both sums are computed wide enough that saturation is a plain compare.
    always_comb begin
        lowest_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                lowest_idx = WAY_W'(i);
            end
        end
        pop_cnt = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            pop_cnt = pop_cnt + PC_W'(pend_new[i]);
        end
        corr_sum   = SUM_W'(corr_cnt_q) + SUM_W'(pop_cnt);
        corr_sat   = (corr_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : corr_sum[CNT_W-1:0];
        uncorr_inc = (uncorr_cnt_q == CNT_MAX) ? CNT_MAX : uncorr_cnt_q + CNT_W'(1);
    end

    // Next-state logic plus one-cycle strobes for the datapath registers.
    // A grant in RD_REQ wins over a same-cycle disable so a granted read is
    // always checked; a collision wins over a same-cycle write grant so stale
    // data is never written.
    always_comb begin
        state_d   = state_q;
        load_wait = 1'b0;
        dec_wait  = 1'b0;
        sample    = 1'b0;
        advance   = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d   = WAIT;
                    load_wait = 1'b1;
                end
            end
            WAIT: begin
                if (!en_i) begin
                    state_d = IDLE;
                end else if (wait_q == '0) begin
                    state_d = RD_REQ;
                end else begin
                    dec_wait = 1'b1;
                end
            end
            RD_REQ: begin
                if (gnt_i) begin
                    state_d = RD_CHK;
                end else if (!en_i) begin
                    state_d = IDLE;
                end
            end
            RD_CHK: begin
                sample = 1'b1;
                if (collision) begin
                    drop    = 1'b1;
                    state_d = RD_REQ;
                end else if (pend_new != '0) begin
                    state_d = WR_REQ;
                end else begin
                    advance   = 1'b1;
                    load_wait = en_i;
                    state_d   = en_i ? WAIT : IDLE;
                end
            end
            WR_REQ: begin
                if (collision) begin
                    drop    = 1'b1;
                    state_d = RD_REQ;
                end else if (gnt_i) begin
                    pop = 1'b1;
                    if ((pending_q & ~lowest) == '0) begin
                        advance   = 1'b1;
                        load_wait = en_i;
                        state_d   = en_i ? WAIT : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, index, wait counter, pending mask and latched corrected lines.
    // Only ways that will actually be written back get their line captured.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            index_q   <= '0;
            wait_q    <= '0;
            pending_q <= '0;
            sweep_q   <= 1'b0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (load_wait) begin
                wait_q <= interval_i;
            end else if (dec_wait) begin
                wait_q <= wait_q - 16'd1;
            end
            if (drop) begin
                pending_q <= '0;
            end else if (sample) begin
                pending_q <= pend_new;
                for (int i = 0; i < NUM_WAYS; i++) begin
                    if (pend_new[i]) begin
                        line_q[i] <= corr_data_i[i*LINE_W +: LINE_W];
                    end
                end
            end else if (pop) begin
                pending_q <= pending_q & ~lowest;
            end
            if (advance) begin
                index_q <= (index_q == LAST_IDX) ? '0 : index_q + IDX_W'(1);
            end
            sweep_q <= advance && (index_q == LAST_IDX);
        end
    end

    // Error counters and the uncorrectable-error pulse. Counts taken in
    // RD_CHK stand even if a collision later forces a re-read of the index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_q <= sample && (err_uncorr_i != '0);
            if (clr_cnt_i) begin
                corr_cnt_q   <= '0;
                uncorr_cnt_q <= '0;
            end else if (sample) begin
                corr_cnt_q <= corr_sat;
                if (err_uncorr_i != '0) begin
                    uncorr_cnt_q <= uncorr_inc;
                end
            end
        end
    end

    // Request outputs are pure functions of the registered state so they stay
    // stable for as long as the arbiter withholds the grant.
    always_comb begin
        req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
        we_o    = (state_q == WR_REQ);
        way_o   = '0;
        wdata_o = '0;
        if (state_q == RD_REQ) begin
            way_o = '1;
        end else if (state_q == WR_REQ) begin
            way_o   = lowest;
            wdata_o = line_q[lowest_idx];
        end
    end

    assign index_o      = index_q;
    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;
    assign uncorr_irq_o = irq_q;
    assign sweep_done_o = sweep_q;
    assign busy_o       = (state_q != IDLE);

endmodule
